// File: rtl/psd_range_scheduler.sv
// PSD range scheduler: sums FFT bin magnitudes into frequency-range
// accumulators over n_avg frames, then drains the range totals as a
// short AXI-Stream packet and starts the next averaging period.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | post-reset: latch n_avg, clear accumulators and counters
//   S_ACCUM | accept bins, steer into range accumulators, count frames
//   S_DUMP  | present range totals on data_out, input stalled
module psd_range_scheduler #(
  parameter int N_RANGES             = 4,
  parameter int START_BIN [N_RANGES] = '{0, 2, 7, 15},
  parameter int FFT_LEN              = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int ACC_WIDTH            = 48,
  parameter int AVG_WIDTH            = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in_tdata,
  input  logic                  data_in_tvalid,
  input  logic                  data_in_tlast,
  output logic                  data_in_tready,
  output logic [ACC_WIDTH-1:0]  data_out_tdata,
  output logic                  data_out_tvalid,
  output logic                  data_out_tlast,
  input  logic                  data_out_tready,
  input  logic [AVG_WIDTH-1:0]  n_avg,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int BIN_W = $clog2(FFT_LEN) + 1;
  localparam int IDX_W = (N_RANGES > 1) ? $clog2(N_RANGES) : 1;
  localparam logic [AVG_WIDTH-1:0] AVG_ONE  = AVG_WIDTH'(1);
  localparam logic [BIN_W-1:0]     BIN_ONE  = BIN_W'(1);
  localparam logic [BIN_W-1:0]     BIN_FULL = BIN_W'(FFT_LEN);
  localparam logic [BIN_W-1:0]     BIN_LAST = BIN_W'(FFT_LEN - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_RANGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP} state_t;

  state_t                 state, state_nxt;
  logic [BIN_W-1:0]       bin_cnt;
  logic [AVG_WIDTH-1:0]   frame_cnt;
  logic [AVG_WIDTH-1:0]   avg_len;
  logic [AVG_WIDTH-1:0]   avg_lat;
  logic [IDX_W-1:0]       out_idx;
  logic [IDX_W-1:0]       idx_inc;
  logic [ACC_WIDTH-1:0]   acc     [N_RANGES];
  logic [ACC_WIDTH-1:0]   acc_upd [N_RANGES];
  logic [ACC_WIDTH:0]     sum_ext;
  logic [IDX_W-1:0]       rng_sel;
  logic                   rng_hit;
  logic                   in_hs, out_hs, frame_end, period_end, dump_end;

  // n_avg of zero means a single frame per period
  assign avg_lat    = (n_avg == '0) ? AVG_ONE : n_avg;
  assign in_hs      = data_in_tvalid && data_in_tready;
  assign out_hs     = data_out_tvalid && data_out_tready;
  assign frame_end  = in_hs && data_in_tlast;
  assign period_end = frame_end && (frame_cnt == avg_len - AVG_ONE);
  assign dump_end   = out_hs && (out_idx == IDX_LAST);
  assign idx_inc    = out_idx + IDX_ONE;

  // Range lookup: highest range whose first bin is at or below bin_cnt
  always_comb begin
    rng_hit = 1'b0;
    rng_sel = '0;
    for (int r = 0; r < N_RANGES; r++) begin
      if (int'(bin_cnt) >= START_BIN[r]) begin
        rng_hit = 1'b1;
        rng_sel = IDX_W'(r);
      end
    end
    if (bin_cnt >= BIN_FULL) rng_hit = 1'b0;
  end

  // Saturating add of the current beat into its range accumulator
  always_comb begin
    for (int r = 0; r < N_RANGES; r++) acc_upd[r] = acc[r];
    sum_ext = {1'b0, acc[rng_sel]} + (ACC_WIDTH + 1)'(data_in_tdata);
    if (in_hs && rng_hit)
      acc_upd[rng_sel] = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
  end

  // Accumulator bank, cleared at period start and after the drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N_RANGES; r++) acc[r] <= '0;
    end else if (state == S_IDLE || dump_end) begin
      for (int r = 0; r < N_RANGES; r++) acc[r] <= '0;
    end else begin
      for (int r = 0; r < N_RANGES; r++) acc[r] <= acc_upd[r];
    end
  end

  // Bin/frame counters and the per-period frame target
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt   <= '0;
      frame_cnt <= '0;
      avg_len   <= '0;
    end else if (state == S_IDLE) begin
      bin_cnt   <= '0;
      frame_cnt <= '0;
      avg_len   <= avg_lat;
    end else if (in_hs) begin
      if (data_in_tlast) begin
        bin_cnt   <= '0;
        frame_cnt <= frame_cnt + AVG_ONE;
      end else if (bin_cnt != BIN_FULL) begin
        bin_cnt <= bin_cnt + BIN_ONE;
      end
    end else if (dump_end) begin
      frame_cnt <= '0;
      avg_len   <= avg_lat;
    end
  end

  // Malformed-frame pulse: tlast not on the final bin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_err <= 1'b0;
    else          frame_err <= frame_end && (bin_cnt != BIN_LAST);
  end

  // Output word register; range 0 is loaded with the final beat included
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_idx        <= '0;
      data_out_tdata <= '0;
    end else if (state == S_ACCUM && period_end) begin
      out_idx        <= '0;
      data_out_tdata <= acc_upd[0];
    end else if (out_hs) begin
      if (dump_end) begin
        out_idx        <= '0;
        data_out_tdata <= '0;
      end else begin
        out_idx        <= idx_inc;
        data_out_tdata <= acc[idx_inc];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_ACCUM;
      S_ACCUM: if (period_end) state_nxt = S_DUMP;
      S_DUMP:  if (dump_end) state_nxt = S_ACCUM;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    data_in_tready  = (state == S_ACCUM);
    data_out_tvalid = (state == S_DUMP);
    busy            = (state == S_DUMP);
    data_out_tlast  = (state == S_DUMP) && (out_idx == IDX_LAST);
  end

endmodule

// File: tb/tb_psd_range_scheduler.sv
// Bench for psd_range_scheduler: a frame-level reference model predicts the
// outputs each cycle for a default instance and a narrow (34-bit) instance
// sharing the same stimulus; literal packet values pin the model.
module tb_psd_range_scheduler;
  localparam int NR = 4;
  localparam int FL = 32;
  localparam int START [NR] = '{0, 2, 7, 15};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] in_tdata;
  logic        in_tvalid, in_tlast;
  logic        in_tready, in_tready_s;
  logic [47:0] out_tdata;
  logic [33:0] out_tdata_s;
  logic        out_tvalid, out_tlast, out_tvalid_s, out_tlast_s;
  logic        out_tready;
  logic [7:0]  n_avg;
  logic        busy, busy_s, ferr, ferr_s;

  always #5 clk = ~clk;

  psd_range_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .data_in_tdata(in_tdata), .data_in_tvalid(in_tvalid),
    .data_in_tlast(in_tlast), .data_in_tready(in_tready),
    .data_out_tdata(out_tdata), .data_out_tvalid(out_tvalid),
    .data_out_tlast(out_tlast), .data_out_tready(out_tready),
    .n_avg(n_avg), .busy(busy), .frame_err(ferr)
  );

  psd_range_scheduler #(.ACC_WIDTH(34)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .data_in_tdata(in_tdata), .data_in_tvalid(in_tvalid),
    .data_in_tlast(in_tlast), .data_in_tready(in_tready_s),
    .data_out_tdata(out_tdata_s), .data_out_tvalid(out_tvalid_s),
    .data_out_tlast(out_tlast_s), .data_out_tready(out_tready),
    .n_avg(n_avg), .busy(busy_s), .frame_err(ferr_s)
  );

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  int rdy_mode = 0;
  longint unsigned cap_q[$];
  longint unsigned cap_s_q[$];

  // reference model state
  int m_phase;   // 0 idle, 1 accumulating, 2 draining
  int m_beats, m_frames, m_navg, m_idx;
  logic m_err;
  longint unsigned m_sum [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  function automatic int range_of(input int b);
    int r = -1;
    for (int i = 0; i < NR; i++) if (b >= START[i]) r = i;
    return r;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned cap = (64'd1 << w) - 64'd1;
    return (v > cap) ? cap : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_beats = 0; m_frames = 0; m_navg = 1; m_idx = 0; m_err = 1'b0;
    for (int i = 0; i < NR; i++) m_sum[i] = 0;
  endtask

  task automatic model_step();
    int r;
    m_err = 1'b0;
    case (m_phase)
      0: begin
        m_phase = 1;
        m_navg = (n_avg == 0) ? 1 : int'(n_avg);
        m_beats = 0; m_frames = 0;
        for (int i = 0; i < NR; i++) m_sum[i] = 0;
      end
      1: if (in_tvalid) begin
        if (m_beats < FL) begin
          r = range_of(m_beats);
          if (r >= 0) m_sum[r] += longint'(in_tdata);
        end
        m_beats++;
        if (in_tlast) begin
          m_err = (m_beats != FL);
          m_beats = 0;
          m_frames++;
          if (m_frames == m_navg) begin
            m_phase = 2;
            m_idx = 0;
          end
        end
      end
      default: if (out_tready) begin
        if (m_idx == NR - 1) begin
          m_phase = 1; m_frames = 0;
          m_navg = (n_avg == 0) ? 1 : int'(n_avg);
          for (int i = 0; i < NR; i++) m_sum[i] = 0;
        end else begin
          m_idx++;
        end
      end
    endcase
  endtask

  initial model_reset();

  // compare both instances against the model every cycle, then advance it
  always @(negedge clk) begin
    if (!reset_n) model_reset();
    chk("in_tready", in_tready, m_phase == 1);
    chk("in_tready_s", in_tready_s, m_phase == 1);
    chk("out_tvalid", out_tvalid, m_phase == 2);
    chk("out_tvalid_s", out_tvalid_s, m_phase == 2);
    chk("busy", busy, m_phase == 2);
    chk("busy_s", busy_s, m_phase == 2);
    chk("frame_err", ferr, m_err);
    chk("frame_err_s", ferr_s, m_err);
    if (m_phase == 2) begin
      chk("out_tdata", out_tdata, sat(m_sum[m_idx], 48));
      chk("out_tdata_s", out_tdata_s, sat(m_sum[m_idx], 34));
      chk("out_tlast", out_tlast, m_idx == NR - 1);
      chk("out_tlast_s", out_tlast_s, m_idx == NR - 1);
      if (out_tready && reset_n) begin
        cap_q.push_back(longint'(out_tdata));
        cap_s_q.push_back(longint'(out_tdata_s));
      end
    end
    if (ferr === 1'b1) err_pulses++;
    if (reset_n) model_step();
  end

  // output-side ready: 0 always 1, 1 pattern 1-0-0-1, 2 random, 3 held low
  initial begin
    int step = 0;
    out_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_tready = 1'b1;
        1: begin out_tready = (step % 4 == 0) || (step % 4 == 3); step++; end
        2: out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    int n = 0;
    logic hs;
    in_tvalid = 1'b1; in_tdata = d; in_tlast = last;
    do begin
      @(negedge clk); hs = in_tready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 200);
    if (!hs) timeout_fail("send_beat");
  endtask

  // mode: 0 ones, 1 bin index, 2 all-ones word, 3 random
  task automatic send_frame(input int len, input int mode, input int gap_max);
    logic [31:0] d;
    for (int b = 0; b < len; b++) begin
      case (mode)
        0: d = 32'd1;
        1: d = 32'(b);
        2: d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      if (gap_max > 0) begin
        int g = $urandom_range(0, gap_max);
        for (int k = 0; k < g; k++) begin
          in_tvalid = 1'b0; in_tlast = 1'b0;
          @(posedge clk); #1;
        end
      end
      send_beat(d, b == len - 1);
    end
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic wait_packet();
    int n = 0;
    while (cap_q.size() < NR && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (cap_q.size() < NR) timeout_fail("wait_packet");
  endtask

  task automatic chk_pkt(input string name, input longint unsigned e0, input longint unsigned e1,
                         input longint unsigned e2, input longint unsigned e3);
    if (cap_q.size() == NR) begin
      chk({name, "_r0"}, cap_q[0], e0);
      chk({name, "_r1"}, cap_q[1], e1);
      chk({name, "_r2"}, cap_q[2], e2);
      chk({name, "_r3"}, cap_q[3], e3);
    end else begin
      chk({name, "_size"}, cap_q.size(), NR);
    end
    cap_q.delete();
    cap_s_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    in_tvalid = 1'b0; in_tlast = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_in_tready", in_tready, 0);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tdata", out_tdata, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", ferr, 0);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    int nav;
    int nf;
    in_tvalid = 1'b0; in_tlast = 1'b0; in_tdata = '0; n_avg = 8'd1;
    @(posedge clk); #1;
    do_reset(3);
    reset_n = 1'b1;
    @(negedge clk); chk("idle_tready", in_tready, 0);
    @(negedge clk); chk("first_tready", in_tready, 1);
    @(posedge clk); #1;

    // ones, single frame
    err_pulses = 0;
    send_frame(32, 0, 0);
    n_avg = 8'd3;
    wait_packet();
    chk_pkt("ones", 2, 5, 8, 17);
    chk("ones_err", err_pulses, 0);

    // bin index, three frames back-to-back
    for (int f = 0; f < 3; f++) send_frame(32, 1, 0);
    wait_packet();
    chk_pkt("idx3", 3, 60, 252, 1173);

    // same with output backpressure
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) send_frame(32, 1, 0);
    n_avg = 8'd2;
    wait_packet();
    rdy_mode = 0;
    chk_pkt("idx3_bp", 3, 60, 252, 1173);

    // short and long frames
    err_pulses = 0;
    send_frame(30, 1, 0);
    send_frame(34, 1, 1);
    n_avg = 8'd8;
    wait_packet();
    chk("badlen_err", err_pulses, 2);
    if (cap_s_q.size() == NR) chk("badlen_r1_s", cap_s_q[1], 40);
    chk_pkt("badlen", 2, 40, 168, 721);

    // saturation in the 34-bit instance
    for (int f = 0; f < 8; f++) send_frame(32, 2, 0);
    n_avg = 8'd3;
    wait_packet();
    if (cap_s_q.size() == NR) begin
      chk("sat_r0_s", cap_s_q[0], 64'h3_FFFF_FFFF);
      chk("sat_r3_s", cap_s_q[3], 64'h3_FFFF_FFFF);
    end else chk("sat_size_s", cap_s_q.size(), NR);
    chk_pkt("sat", 64'd16 * 64'hFFFF_FFFF, 64'd40 * 64'hFFFF_FFFF,
            64'd64 * 64'hFFFF_FFFF, 64'd136 * 64'hFFFF_FFFF);

    // reset at bin 10 of frame 2
    send_frame(32, 3, 0);
    for (int b = 0; b < 10; b++) send_beat(32'(b + 100), 1'b0);
    do_reset(2);
    n_avg = 8'd1;
    reset_n = 1'b1;
    send_frame(32, 1, 0);
    wait_packet();
    chk_pkt("post_rst", 1, 20, 84, 391);

    // reset while the drain is stalled: no packet may complete
    rdy_mode = 3;
    send_frame(32, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_busy", busy, 1);
    do_reset(2);
    reset_n = 1'b1;
    rdy_mode = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("no_partial_pkt", cap_q.size(), 0);
    send_frame(32, 0, 0);
    wait_packet();
    chk_pkt("post_rst2", 2, 5, 8, 17);

    // randomized periods; model checks every cycle
    rdy_mode = 2;
    nav = 1;
    for (int p = 0; p < 6; p++) begin
      nf = (nav == 0) ? 1 : nav;
      for (int f = 0; f < nf; f++)
        send_frame(($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : 32, 3, 2);
      nav = $urandom_range(0, 3);
      n_avg = 8'(nav);
      wait_packet();
      cap_q.delete();
      cap_s_q.delete();
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
